// File: rtl/div_result_bank.sv
// div_result_bank: 2-entry skid FIFO, round/saturate stage and per-channel
// quotient/fraction register bank fed by a tagged AXI-Stream divider output.
module div_result_bank #(
  parameter int QUOT_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int TDATA_W = 25,
  parameter int NCH     = 4,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TDATA_W-1:0]    s_axis_div_tdata,
  input  logic                  s_axis_div_tvalid,
  output logic                  s_axis_div_tready,
  input  logic [CH_W:0]         s_axis_div_tuser,
  input  logic                  round_en,
  input  logic                  hold,
  input  logic [NCH-1:0]        dbz_clr,
  output logic [NCH*QUOT_W-1:0] quotient_bus,
  output logic [NCH*FRAC_W-1:0] remainder_bus,
  output logic                  upd_valid,
  output logic [CH_W-1:0]       upd_ch,
  output logic                  upd_sat,
  output logic [NCH-1:0]        dbz_sticky
);

  localparam int DW = QUOT_W + FRAC_W;
  localparam int EW = DW + CH_W + 1;

  logic [EW-1:0]     fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              push;
  logic              pop;

  logic [EW-1:0]     head;
  logic [QUOT_W-1:0] h_quot;
  logic [FRAC_W-1:0] h_frac;
  logic              h_dbz;
  logic [CH_W-1:0]   h_ch;
  logic              h_in_range;

  logic [QUOT_W-1:0] proc_quot;
  logic [FRAC_W-1:0] proc_frac;
  logic              proc_sat;

  logic              p_valid;
  logic [CH_W-1:0]   p_ch;
  logic              p_dbz;
  logic              p_sat;
  logic [QUOT_W-1:0] p_quot;
  logic [FRAC_W-1:0] p_frac;
  logic              p_write;

  logic [QUOT_W-1:0] quot_bank [NCH];
  logic [FRAC_W-1:0] frac_bank [NCH];
  logic [NCH-1:0]    set_mask;

  // P drains every unheld cycle, so a pop only needs data and no hold.
  always_comb begin
    push       = s_axis_div_tvalid & s_axis_div_tready;
    pop        = (count != 2'd0) & ~hold;
    p_write    = p_valid & ~hold;
    count_next = count;
    if (push && !pop) count_next = count + 2'd1;
    else if (!push && pop) count_next = count - 2'd1;
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {s_axis_div_tuser, s_axis_div_tdata[DW-1:0]};
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      count             <= 2'd0;
      s_axis_div_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count             <= count_next;
      s_axis_div_tready <= (count_next < 2'd2);
    end
  end

  // Decode the FIFO head and apply divide-by-zero / rounding rules.
  always_comb begin
    head       = fifo_mem[rd_ptr];
    h_quot     = head[DW-1:FRAC_W];
    h_frac     = head[FRAC_W-1:0];
    h_dbz      = head[DW];
    h_ch       = head[EW-1:DW+1];
    h_in_range = (32'(h_ch) < NCH);
    proc_quot  = h_quot;
    proc_frac  = h_frac;
    proc_sat   = 1'b0;
    if (h_dbz) begin
      proc_quot = '1;
      proc_frac = '0;
    end else if (round_en && h_frac[FRAC_W-1]) begin
      if (&h_quot) proc_sat = 1'b1;
      else proc_quot = h_quot + {{(QUOT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stage P: frozen under hold; out-of-range channels are popped but never made valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_ch    <= '0;
      p_dbz   <= 1'b0;
      p_sat   <= 1'b0;
      p_quot  <= '0;
      p_frac  <= '0;
    end else if (!hold) begin
      p_valid <= pop & h_in_range;
      if (pop) begin
        p_ch   <= h_ch;
        p_dbz  <= h_dbz;
        p_sat  <= proc_sat;
        p_quot <= proc_quot;
        p_frac <= proc_frac;
      end
    end
  end

  // Sticky set request from the write currently leaving P.
  always_comb begin
    set_mask = '0;
    if (p_write && p_dbz) set_mask[p_ch] = 1'b1;
  end

  // Stage B: bank write, update pulse and sticky flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        quot_bank[k] <= '0;
        frac_bank[k] <= '0;
      end
      upd_valid  <= 1'b0;
      upd_ch     <= '0;
      upd_sat    <= 1'b0;
      dbz_sticky <= '0;
    end else begin
      upd_valid  <= p_write;
      dbz_sticky <= (dbz_sticky & ~dbz_clr) | set_mask;
      if (p_write) begin
        quot_bank[p_ch] <= p_quot;
        frac_bank[p_ch] <= p_frac;
        upd_ch          <= p_ch;
        upd_sat         <= p_sat;
      end
    end
  end

  // Flatten the bank onto the snapshot buses.
  always_comb begin
    quotient_bus  = '0;
    remainder_bus = '0;
    for (int k = 0; k < NCH; k++) begin
      quotient_bus[k*QUOT_W +: QUOT_W]  = quot_bank[k];
      remainder_bus[k*FRAC_W +: FRAC_W] = frac_bank[k];
    end
  end

endmodule

// File: tb/tb_div_result_bank.sv
// tb_div_result_bank: randomized self-checking bench with a queue-based reference model.
module tb_div_result_bank;

  localparam int QW  = 16;
  localparam int FW  = 8;
  localparam int TW  = 25;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TW-1:0]     tdata;
  logic              tvalid;
  logic              tready;
  logic [CW:0]       tuser;
  logic              round_en;
  logic              hold;
  logic [NCH-1:0]    dbz_clr;
  logic [NCH*QW-1:0] quotient_bus;
  logic [NCH*FW-1:0] remainder_bus;
  logic              upd_valid;
  logic [CW-1:0]     upd_ch;
  logic              upd_sat;
  logic [NCH-1:0]    dbz_sticky;

  div_result_bank #(.QUOT_W(QW), .FRAC_W(FW), .TDATA_W(TW), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_div_tdata(tdata), .s_axis_div_tvalid(tvalid),
    .s_axis_div_tready(tready), .s_axis_div_tuser(tuser),
    .round_en(round_en), .hold(hold), .dbz_clr(dbz_clr),
    .quotient_bus(quotient_bus), .remainder_bus(remainder_bus),
    .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_sat(upd_sat),
    .dbz_sticky(dbz_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {logic [TW-1:0] data; logic [CW:0] user; int cyc;} beat_t;
  typedef struct {int ch; logic sat; logic [QW-1:0] q; logic [FW-1:0] f; int cyc;} upd_t;

  beat_t tx_q[$];
  beat_t acc_q[$];
  upd_t  obs_q[$];
  int    cyc = 0;
  int    stall_cnt = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  logic  will_accept;

  logic [QW-1:0]  m_q [NCH];
  logic [FW-1:0]  m_f [NCH];
  logic [NCH-1:0] m_sticky;

  // Edge counter: after edge k the bench sees cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: presents the queue head, a beat leaves when tready was high.
  initial begin
    beat_t b;
    tvalid = 1'b0; tdata = '0; tuser = '0; will_accept = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tvalid && will_accept) begin
        b = tx_q.pop_front();
        b.cyc = cyc;
        acc_q.push_back(b);
      end
      if (tx_q.size() > 0) begin
        tvalid = 1'b1; tdata = tx_q[0].data; tuser = tx_q[0].user;
        will_accept = tready;
        if (tready !== 1'b1) stall_cnt++;
      end else begin
        tvalid = 1'b0; will_accept = 1'b0;
      end
    end
  end

  // Update monitor: records each pulse with the bank contents it produced.
  initial begin
    upd_t u;
    forever begin
      @(negedge clk);
      if (upd_valid === 1'b1) begin
        u.ch  = int'(upd_ch);
        u.sat = upd_sat;
        u.q   = quotient_bus[u.ch*QW +: QW];
        u.f   = remainder_bus[u.ch*FW +: FW];
        u.cyc = cyc;
        obs_q.push_back(u);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference result {sat, quotient, fraction} from the divider beat rules.
  function automatic logic [QW+FW:0] ref_result(logic [TW-1:0] data, logic dbz, logic rnd);
    int unsigned d, q, f;
    logic sat;
    d = data;
    q = (d >> FW) % (1 << QW);
    f = d % (1 << FW);
    sat = 1'b0;
    if (dbz) begin
      q = (1 << QW) - 1;
      f = 0;
    end else if (rnd && f >= (1 << (FW - 1))) begin
      if (q == (1 << QW) - 1) sat = 1'b1;
      else q = q + 1;
    end
    return {sat, QW'(q), FW'(f)};
  endfunction

  function automatic logic [NCH*QW-1:0] pack_q();
    logic [NCH*QW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*QW +: QW] = m_q[i];
    return v;
  endfunction

  function automatic logic [NCH*FW-1:0] pack_f();
    logic [NCH*FW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*FW +: FW] = m_f[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_q[i] = '0;
      m_f[i] = '0;
    end
    m_sticky = '0;
  endtask

  task automatic send(int ch, logic dbz, logic [TW-1:0] d);
    beat_t b;
    b.data = d;
    b.user = {CW'(ch), dbz};
    b.cyc  = 0;
    tx_q.push_back(b);
  endtask

  task automatic wait_obs(int n, int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; round_en = 1'b0; hold = 1'b0; dbz_clr = '0;
    model_clear();
    #22;
    n_tests++;
    if (tready !== 1'b0 || upd_valid !== 1'b0 || upd_ch !== '0 || upd_sat !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: tready=%b upd_valid=%b upd_ch=%0d upd_sat=%b, required all 0",
               tready, upd_valid, upd_ch, upd_sat);
    end
    n_tests++;
    if (quotient_bus !== '0 || remainder_bus !== '0 || dbz_sticky !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_bank: q=%h f=%h sticky=%b, required 0", quotient_bus, remainder_bus, dbz_sticky);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (tready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_tready: got %b, required 1", tready);
    end
  endtask

  task automatic test_single();
    beat_t a; upd_t u; logic [QW+FW:0] r;
    @(negedge clk); round_en = 1'b0;
    send(2, 1'b0, 25'h0123480);
    wait_obs(1, 20);
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != 1 || acc_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL single_count: %0d updates for %0d beats, required 1/1", obs_q.size(), acc_q.size());
    end else begin
      a = acc_q.pop_front(); u = obs_q.pop_front();
      r = ref_result(a.data, a.user[0], 1'b0);
      n_tests++;
      if (u.cyc - a.cyc != 2) begin
        n_fail++;
        $display("[TB] FAIL single_latency: %0d edges, required 2", u.cyc - a.cyc);
      end
      n_tests++;
      if (u.ch != 2 || u.q !== 16'h1234 || u.f !== 8'h80 || u.sat !== 1'b0 || {u.sat, u.q, u.f} !== r) begin
        n_fail++;
        $display("[TB] FAIL single_value: ch=%0d q=%h f=%h sat=%b, required ch=2 q=1234 f=80 sat=0",
                 u.ch, u.q, u.f, u.sat);
      end
      m_q[2] = r[QW+FW-1:FW]; m_f[2] = r[FW-1:0];
    end
    n_tests++;
    if (quotient_bus !== pack_q() || remainder_bus !== pack_f()) begin
      n_fail++;
      $display("[TB] FAIL single_bank: q=%h f=%h, required q=%h f=%h", quotient_bus, remainder_bus, pack_q(), pack_f());
    end
  endtask

  task automatic test_round();
    beat_t a; upd_t u; logic [QW+FW:0] r;
    @(negedge clk); round_en = 1'b1;
    send(2, 1'b0, 25'h0123480);
    send(3, 1'b0, 25'h0FFFF80);
    wait_obs(2, 30);
    n_tests++;
    if (obs_q.size() != 2 || acc_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL round_count: %0d updates, required 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        a = acc_q.pop_front(); u = obs_q.pop_front();
        r = ref_result(a.data, a.user[0], 1'b1);
        n_tests++;
        if (u.ch != int'(a.user[CW:1]) || {u.sat, u.q, u.f} !== r) begin
          n_fail++;
          $display("[TB] FAIL round_beat%0d: ch=%0d sat=%b q=%h f=%h, required ch=%0d sat=%b q=%h f=%h",
                   i, u.ch, u.sat, u.q, u.f, a.user[CW:1], r[QW+FW], r[QW+FW-1:FW], r[FW-1:0]);
        end
        m_q[a.user[CW:1]] = r[QW+FW-1:FW]; m_f[a.user[CW:1]] = r[FW-1:0];
      end
    end
    n_tests++;
    if (quotient_bus[2*QW +: QW] !== 16'h1235 || quotient_bus[3*QW +: QW] !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL round_bank: ch2=%h ch3=%h, required 1235 ffff",
               quotient_bus[2*QW +: QW], quotient_bus[3*QW +: QW]);
    end
    @(negedge clk); round_en = 1'b0;
  endtask

  task automatic test_dbz();
    upd_t u;
    send(1, 1'b1, 25'($urandom));
    wait_obs(1, 20);
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL dbz_count: %0d updates, required 1", obs_q.size());
    end else begin
      u = obs_q.pop_front();
      n_tests++;
      if (u.ch != 1 || u.q !== 16'hFFFF || u.f !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL dbz_value: ch=%0d q=%h f=%h, required ch=1 q=ffff f=00", u.ch, u.q, u.f);
      end
    end
    void'(acc_q.pop_front());
    m_q[1] = 16'hFFFF; m_f[1] = 8'h00; m_sticky[1] = 1'b1;
    n_tests++;
    if (dbz_sticky !== m_sticky) begin
      n_fail++;
      $display("[TB] FAIL dbz_sticky_set: got %b, required %b", dbz_sticky, m_sticky);
    end
    @(negedge clk); dbz_clr = 4'b0010;
    @(negedge clk); dbz_clr = '0;
    m_sticky[1] = 1'b0;
    n_tests++;
    if (dbz_sticky !== m_sticky) begin
      n_fail++;
      $display("[TB] FAIL dbz_sticky_clear: got %b, required %b", dbz_sticky, m_sticky);
    end
    dbz_clr = 4'b0010;
    send(1, 1'b1, 25'($urandom));
    wait_obs(1, 20);
    dbz_clr = '0;
    m_sticky[1] = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (obs_q.size() != 1 || dbz_sticky !== m_sticky) begin
      n_fail++;
      $display("[TB] FAIL dbz_set_beats_clear: updates=%0d sticky=%b, required 1 and %b",
               obs_q.size(), dbz_sticky, m_sticky);
    end
    obs_q.delete(); acc_q.delete();
  endtask

  task automatic test_hold();
    beat_t a; upd_t u; logic [QW+FW:0] r; logic rnd;
    rnd = 1'($urandom);
    @(negedge clk); hold = 1'b1; round_en = rnd;
    for (int i = 0; i < 4; i++) send(i, 1'b0, 25'($urandom));
    repeat (8) @(negedge clk);
    #1;
    n_tests++;
    if (acc_q.size() != 2 || tready !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL hold_stall: accepted=%0d tready=%b updates=%0d, required 2 0 0",
               acc_q.size(), tready, obs_q.size());
    end
    n_tests++;
    if (quotient_bus !== pack_q() || remainder_bus !== pack_f()) begin
      n_fail++;
      $display("[TB] FAIL hold_frozen: q=%h f=%h, required q=%h f=%h", quotient_bus, remainder_bus, pack_q(), pack_f());
    end
    hold = 1'b0;
    wait_obs(4, 40);
    n_tests++;
    if (obs_q.size() != 4 || acc_q.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL hold_release_count: %0d updates, required 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        a = acc_q.pop_front(); u = obs_q.pop_front();
        r = ref_result(a.data, a.user[0], rnd);
        n_tests++;
        if (u.ch != i || {u.sat, u.q, u.f} !== r) begin
          n_fail++;
          $display("[TB] FAIL hold_beat%0d: ch=%0d sat=%b q=%h f=%h, required ch=%0d sat=%b q=%h f=%h",
                   i, u.ch, u.sat, u.q, u.f, i, r[QW+FW], r[QW+FW-1:FW], r[FW-1:0]);
        end
        m_q[i] = r[QW+FW-1:FW]; m_f[i] = r[FW-1:0];
      end
    end
    obs_q.delete(); acc_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t a; upd_t u; logic [QW+FW:0] r; logic rnd; int first;
    rnd = 1'($urandom);
    @(negedge clk); round_en = rnd; stall_cnt = 0;
    for (int i = 0; i < 16; i++) send(i % NCH, ($urandom_range(0, 7) == 0), 25'($urandom));
    wait_obs(16, 100);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (stall_cnt != 0 || tready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_tready: stalls=%0d tready=%b, required 0 stalls and 1", stall_cnt, tready);
    end
    n_tests++;
    if (obs_q.size() != 16 || acc_q.size() != 16) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: %0d updates, required 16", obs_q.size());
    end else begin
      first = obs_q[0].cyc;
      for (int i = 0; i < 16; i++) begin
        a = acc_q.pop_front(); u = obs_q.pop_front();
        r = ref_result(a.data, a.user[0], rnd);
        n_tests++;
        if (u.ch != i % NCH || {u.sat, u.q, u.f} !== r || u.cyc != first + i) begin
          n_fail++;
          $display("[TB] FAIL b2b_beat%0d: ch=%0d sat=%b q=%h f=%h cyc=%0d, required ch=%0d sat=%b q=%h f=%h cyc=%0d",
                   i, u.ch, u.sat, u.q, u.f, u.cyc, i % NCH, r[QW+FW], r[QW+FW-1:FW], r[FW-1:0], first + i);
        end
        m_q[i % NCH] = r[QW+FW-1:FW]; m_f[i % NCH] = r[FW-1:0];
        if (a.user[0]) m_sticky[i % NCH] = 1'b1;
      end
    end
    n_tests++;
    if (quotient_bus !== pack_q() || remainder_bus !== pack_f() || dbz_sticky !== m_sticky) begin
      n_fail++;
      $display("[TB] FAIL b2b_bank: q=%h f=%h sticky=%b, required q=%h f=%h sticky=%b",
               quotient_bus, remainder_bus, dbz_sticky, pack_q(), pack_f(), m_sticky);
    end
    obs_q.delete(); acc_q.delete();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); hold = 1'b1;
    send(0, 1'b0, 25'($urandom));
    send(3, 1'b1, 25'($urandom));
    for (int i = 0; i < 20 && (acc_q.size() < 2 || tvalid); i++) @(negedge clk);
    n_tests++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL resetmid_buffered: accepted=%0d, required 2", acc_q.size());
    end
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (quotient_bus !== '0 || remainder_bus !== '0 || dbz_sticky !== '0 || tready !== 1'b0 || upd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL resetmid_outputs: q=%h f=%h sticky=%b tready=%b upd=%b, required all 0",
               quotient_bus, remainder_bus, dbz_sticky, tready, upd_valid);
    end
    @(negedge clk); hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != 0 || tready !== 1'b1 || quotient_bus !== pack_q() || remainder_bus !== pack_f()) begin
      n_fail++;
      $display("[TB] FAIL resetmid_discard: updates=%0d tready=%b q=%h, required 0 1 0",
               obs_q.size(), tready, quotient_bus);
    end
    acc_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round();
    test_dbz();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_result_bank.md
# div_result_bank

Multi-channel result unpacker for the AXI-Stream divider output in the frequency-synthesis path. It accepts divider beats tagged with a channel ID and a divide-by-zero flag, buffers them in a 2-entry skid FIFO, and optionally rounds and saturates the integer quotient. It writes each result into a per-channel quotient/fraction register bank that the tuning-word logic reads as coherent snapshots.

## Interface
- QUOT_W, 16, integer quotient width (unsigned)
- FRAC_W, 8, fractional remainder width
- TDATA_W, 25, divider tdata width; must be ≥ QUOT_W+FRAC_W; bits above QUOT_W+FRAC_W ignored
- NCH, 4, channel count (≥1); CH_W = max(1, clog2(NCH)), derived
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_axis_div_tdata  in  TDATA_W  [QUOT_W+FRAC_W-1:FRAC_W] quotient, [FRAC_W-1:0] fraction
- s_axis_div_tvalid  in  1  beat valid
- s_axis_div_tready  out  1  FIFO not full (registered)
- s_axis_div_tuser  in  CH_W+1  [CH_W:1] channel, [0] divide-by-zero
- round_en  in  1  1 = round quotient to nearest, sampled at pop
- hold  in  1  1 = freeze bank (snapshot read); stalls pop and write
- dbz_clr  in  NCH  per-channel clear of dbz_sticky
- quotient_bus  out  NCH*QUOT_W  channel k at [k*QUOT_W +: QUOT_W]
- remainder_bus  out  NCH*FRAC_W  channel k at [k*FRAC_W +: FRAC_W]
- upd_valid  out  1  one-cycle pulse: bank entry written
- upd_ch  out  CH_W  channel written (valid with upd_valid)
- upd_sat  out  1  rounding saturated (valid with upd_valid)
- dbz_sticky  out  NCH  sticky divide-by-zero per channel

## Operation
- Stage F: 2-entry FIFO. Push on tvalid & tready. tready = (count < 2), registered.
- Stage P: pop when FIFO non-empty, hold = 0, and P empty or P draining in the same cycle. Load P with the processed result:
  - dbz = 1: quotient = all-ones, fraction = 0.
  - round_en = 1 and fraction MSB = 1: quotient + 1. If the quotient was all-ones, it stays all-ones and sat = 1.
  - Otherwise: raw quotient and fraction, sat = 0.
  - Fraction is always passed through unchanged, except on dbz.
- Stage B: when P is valid and hold = 0, write bank[ch]. Pulse upd_valid / upd_ch / upd_sat. If dbz, set dbz_sticky[ch].
- Channel ≥ NCH: beat is consumed and dropped. No bank write, no upd_valid, no sticky change.
- dbz_sticky: a set wins over dbz_clr in the same cycle for the same bit.
- hold = 1: P and the bank are frozen and no pops occur. The FIFO continues to accept until full, then tready = 0. Beats are never lost or reordered.

## Timing
- Reset (async assert): FIFO empty, P empty, bank all zero, upd_valid = 0, upd_ch = 0, upd_sat = 0, dbz_sticky = 0, tready = 0. tready = 1 from the first rising edge after rst_n deasserts.
- Latency: a beat accepted at edge E0 (hold = 0, pipeline empty) is in P after E1 and in the bank after E2. upd_valid is high during the cycle following E2.
- Throughput: 1 beat per cycle sustained with hold = 0; tready stays 1.
- Full FIFO with a pop at edge E: count drops to 1 and tready = 1 in the next cycle. No push is possible while tready = 0.
- Releasing hold: a pop and a P→bank write both occur on the first edge with hold = 0.
- Reset mid-stream: all buffered beats are discarded and no upd_valid follows.

## Test plan
- Single beat, ch 2, tdata = 0x0123480, round_en = 0 → 2 cycles later bank[2] = {0x1234, 0x80}, upd_valid for 1 cycle, upd_ch = 2, upd_sat = 0.
- Same beat with round_en = 1 → quotient 0x1235, fraction 0x80. Quotient 0xFFFF with fraction 0x80 → quotient 0xFFFF, upd_sat = 1.
- tuser dbz = 1 on ch 1 → bank[1] = {0xFFFF, 0x00}, dbz_sticky[1] = 1. dbz_clr[1] pulsed alone → 0. Clear in the same cycle as a new dbz → stays 1.
- hold = 1 with 4 back-to-back beats to ch 0..3 → 2 accepted, tready = 0, bank unchanged. Release hold → all 4 written in order, one upd_valid per beat, no loss.
- Continuous tvalid for 16 cycles, channels cycling 0..3 → 16 consecutive upd_valid pulses, the final bank equals the last beat per channel, and tready never drops.
- rst_n asserted with 2 beats buffered → outputs zero immediately, and no upd_valid after release.
